// File: rtl/time_display_mux.sv
// HH.MM driver for a 4-digit multiplexed, active-low seven-segment display.
// Build option DISPLAY_BLINK_EN adds a blink of the whole display while set_mode is high.
module time_display_mux #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       userclock,
  input  logic       reset,
  input  logic [7:0] minutes,
  input  logic [6:0] hours,
  input  logic       set_mode,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } conv_state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble iteration on {bcd[11:0], bin[7:0]}: correct nibbles, then shift.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int n = 0; n < 3; n++) begin
      if (r[8+4*n +: 4] >= 4'd5) begin
        r[8+4*n +: 4] = r[8+4*n +: 4] + 4'd3;
      end
    end
    return r << 1;
  endfunction

  logic [CW-1:0] cnt;
  logic          scan_tick;
  logic [1:0]    idx;
  logic          ghost;

  conv_state_t   state;
  logic          start_pend;
  logic          start;
  logic [2:0]    iter;
  logic [19:0]   min_sh;
  logic [19:0]   hr_sh;
  logic [7:0]    min_snap;
  logic [6:0]    hr_snap;
  logic          min_over;
  logic          hr_over;

  logic [6:0]    pend [4];
  logic [6:0]    disp [4];

  logic [3:0]    an_s;
  logic          dp_s;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;
  logic          blink_mask;

  assign scan_tick = (cnt == CNT_MAX);
  assign start     = start_pend | (scan_tick & (idx == 2'd2));
  assign min_over  = (min_snap > 8'd59);
  assign hr_over   = (hr_snap > 7'd23);

  // Prescaler, digit index and the frame-boundary commit of pending digits.
  always_ff @(posedge userclock) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= 2'd3;
      ghost <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        disp[i] <= SEG_BLANK;
      end
    end else begin
      cnt   <= scan_tick ? '0 : cnt + 1'b1;
      ghost <= scan_tick;
      if (scan_tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          for (int i = 0; i < 4; i++) begin
            disp[i] <= pend[i];
          end
        end
      end
    end
  end

  // Conversion engine: snapshot, 8 dabble iterations, then publish to pending digits.
  always_ff @(posedge userclock) begin
    if (reset) begin
      state      <= IDLE;
      start_pend <= 1'b1;
      iter       <= '0;
      min_sh     <= '0;
      hr_sh      <= '0;
      min_snap   <= '0;
      hr_snap    <= '0;
      for (int i = 0; i < 4; i++) begin
        pend[i] <= SEG_BLANK;
      end
    end else begin
      start_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            min_sh   <= {12'd0, minutes};
            hr_sh    <= {13'd0, hours};
            min_snap <= minutes;
            hr_snap  <= hours;
            iter     <= '0;
            state    <= CONV;
          end
        end
        CONV: begin
          min_sh <= dabble_step(min_sh);
          hr_sh  <= dabble_step(hr_sh);
          iter   <= iter + 3'd1;
          if (iter == 3'd7) begin
            state <= DONE;
          end
        end
        DONE: begin
          pend[0] <= min_over ? SEG_DASH : seg_code(min_sh[11:8]);
          pend[1] <= min_over ? SEG_DASH : seg_code(min_sh[15:12]);
          pend[2] <= hr_over  ? SEG_DASH : seg_code(hr_sh[11:8]);
          if (hr_over) begin
            pend[3] <= SEG_DASH;
          end else if (hr_sh[15:12] == 4'd0) begin
            pend[3] <= SEG_BLANK;
          end else begin
            pend[3] <= seg_code(hr_sh[15:12]);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // Blink phase restarts in the on-phase whenever set_mode is low.
  always_ff @(posedge userclock) begin
    if (reset || !set_mode) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_mask = set_mode & ~blink_on;
`else
  localparam int unused_blink_hz = BLINK_HZ;
  logic unused_set_mode;

  assign unused_set_mode = set_mode;
  assign blink_mask      = 1'b0;
`endif

  // Tick cycle blanks everything; the following cycle lights the newly selected digit.
  always_comb begin
    an_nxt  = an_s;
    seg_nxt = seg;
    dp_nxt  = dp_s;
    if (scan_tick) begin
      an_nxt  = 4'b1111;
      seg_nxt = SEG_BLANK;
      dp_nxt  = 1'b1;
    end else if (ghost) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = disp[idx];
      dp_nxt  = (idx != 2'd2);
    end
  end

  always_ff @(posedge userclock) begin
    if (reset) begin
      an_s <= 4'b1111;
      dp_s <= 1'b1;
      seg  <= SEG_BLANK;
      an   <= 4'b1111;
      dp   <= 1'b1;
    end else begin
      an_s <= an_nxt;
      dp_s <= dp_nxt;
      seg  <= seg_nxt;
      an   <= blink_mask ? 4'b1111 : an_nxt;
      dp   <= blink_mask ? 1'b1 : dp_nxt;
    end
  end

endmodule

// File: tb/tb_time_display_mux.sv
// Directed bench for time_display_mux at DIV=16; expected segment patterns are hand-derived.
module tb_time_display_mux;

  localparam int CLK_HZ   = 1600;
  localparam int SCAN_HZ  = 100;
  localparam int BLINK_HZ = 50;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S2    = 7'b0100100;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S4    = 7'b0011001;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S7    = 7'b1111000;
  localparam logic [6:0] S9    = 7'b0010000;
  localparam logic [6:0] SDASH = 7'b0111111;
  localparam logic [6:0] SBLNK = 7'b1111111;

  logic       userclock = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] minutes   = 8'd0;
  logic [6:0] hours     = 7'd0;
  logic       set_mode  = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;

  time_display_mux #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ),
    .BLINK_HZ(BLINK_HZ)
  ) dut (
    .userclock(userclock),
    .reset    (reset),
    .minutes  (minutes),
    .hours    (hours),
    .set_mode (set_mode),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  always #5 userclock = ~userclock;

  task automatic tick(input int n);
    repeat (n) @(posedge userclock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] m, input logic [6:0] h, input logic sm);
    minutes  = m;
    hours    = h;
    set_mode = sm;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] ea, input logic [6:0] es,
                             input logic ed);
    checks++;
    assert ({an, seg, dp} === {ea, es, ed}) else begin
      errors++;
      $error("[TB] FAIL %s: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
             tag, an, seg, dp, ea, es, ed);
    end
  endtask

  // Bounded wait until the anodes show the requested pattern.
  task automatic waitAn(input string tag, input logic [3:0] target);
    int n;
    n = 0;
    while (an !== target && n < 80) begin
      tick(1);
      n++;
    end
    checks++;
    assert (an === target) else begin
      errors++;
      $error("[TB] FAIL %s: timeout, an=%b, expected an=%b", tag, an, target);
    end
  endtask

  task automatic skipFrame(input string tag);
    waitAn(tag, 4'b1110);
    tick(16);
  endtask

  task automatic checkFrame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    waitAn({tag, "_sync"}, 4'b1110);
    checkOutput({tag, "_d0"}, 4'b1110, s0, 1'b1);
    tick(15);
    checkOutput({tag, "_ghost"}, 4'b1111, SBLNK, 1'b1);
    tick(1);
    checkOutput({tag, "_d1"}, 4'b1101, s1, 1'b1);
    tick(16);
    checkOutput({tag, "_d2"}, 4'b1011, s2, 1'b0);
    tick(16);
    checkOutput({tag, "_d3"}, 4'b0111, s3, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    applyStimulus(8'd0, 7'd0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput("reset_hold", 4'b1111, SBLNK, 1'b1);
    end
    reset = 1'b0;

    tick(15);
    checkOutput("rel_15", 4'b1111, SBLNK, 1'b1);
    tick(1);
    checkOutput("rel_16_ghost", 4'b1111, SBLNK, 1'b1);
    tick(1);
    checkOutput("rel_17_d0", 4'b1110, S0, 1'b1);
    tick(16);
    checkOutput("rel_d1", 4'b1101, S0, 1'b1);
    tick(16);
    checkOutput("rel_d2", 4'b1011, S0, 1'b0);
    tick(16);
    checkOutput("rel_d3_blank", 4'b0111, SBLNK, 1'b1);

    applyStimulus(8'd45, 7'd9, 1'b0);
    skipFrame("m45_skip");
    checkFrame("m45h09", S5, S4, S9, SBLNK);

    applyStimulus(8'd60, 7'd23, 1'b0);
    skipFrame("range_skip");
    checkFrame("m60h23", SDASH, SDASH, S3, S2);

    applyStimulus(8'd12, 7'd15, 1'b0);
    skipFrame("m12_skip");
    checkFrame("m12h15", S2, S1, S5, S1);

    waitAn("chg_sync", 4'b1110);
    checkOutput("chg_d0_old", 4'b1110, S2, 1'b1);
    tick(16);
    checkOutput("chg_d1_old", 4'b1101, S1, 1'b1);
    applyStimulus(8'd34, 7'd15, 1'b0);
    tick(8);
    checkOutput("chg_d1_hold", 4'b1101, S1, 1'b1);
    tick(8);
    checkOutput("chg_d2", 4'b1011, S5, 1'b0);
    tick(16);
    checkOutput("chg_d3", 4'b0111, S1, 1'b1);
    tick(15);
    checkOutput("chg_wrap_ghost", 4'b1111, SBLNK, 1'b1);
    tick(1);
    checkOutput("chg_d0_new", 4'b1110, S4, 1'b1);
    tick(16);
    checkOutput("chg_d1_new", 4'b1101, S3, 1'b1);

    waitAn("rst_sync", 4'b1011);
    tick(15);
    checkOutput("rst_start_tick", 4'b1111, SBLNK, 1'b1);
    applyStimulus(8'd7, 7'd20, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(1);
    checkOutput("rst_mid_conv", 4'b1111, SBLNK, 1'b1);
    tick(1);
    checkOutput("rst_mid_conv_hold", 4'b1111, SBLNK, 1'b1);
    reset = 1'b0;
    tick(16);
    checkOutput("rst_rel_ghost", 4'b1111, SBLNK, 1'b1);
    tick(1);
    checkOutput("rst_rel_d0", 4'b1110, S7, 1'b1);
    tick(16);
    checkOutput("rst_rel_d1", 4'b1101, S0, 1'b1);
    tick(16);
    checkOutput("rst_rel_d2", 4'b1011, S0, 1'b0);
    tick(16);
    checkOutput("rst_rel_d3", 4'b0111, S2, 1'b1);

`ifdef DISPLAY_BLINK_EN
    waitAn("blink_sync", 4'b1110);
    applyStimulus(8'd7, 7'd20, 1'b1);
    tick(16);
    checkOutput("blink_on_d1", 4'b1101, S0, 1'b1);
    tick(1);
    checkOutput("blink_off_start", 4'b1111, S0, 1'b1);
    tick(15);
    checkOutput("blink_off_end", 4'b1111, S0, 1'b1);
    tick(1);
    checkOutput("blink_on_d2", 4'b1011, S0, 1'b0);
    applyStimulus(8'd7, 7'd20, 1'b0);
    checkFrame("blink_released", S7, S0, S0, S2);
`else
    applyStimulus(8'd7, 7'd20, 1'b1);
    checkFrame("set_mode_ignored", S7, S0, S0, S2);
    applyStimulus(8'd7, 7'd20, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
